z80_io_cycle_gen: RTL and testbench

- Synthesizable, parametrised Z80 I/O bus-cycle master for the MSX cartridge slot side of the design.
- Replaces fixed-timing write-only cycle generation with:
  - configurable T-state length and strobe edges,
  - read and write cycles,
  - wait-state extension from slot_wait,
  - timeout abort.
- Upstream logic issues request/response transactions. The block drives slot address, data and strobes with Z80-accurate sequencing (T1, T2, TW..., T3, gap).
- Used for on-chip self-test and loader sequencing against the VDP I/O ports.

---
 rtl/z80_io_cycle_gen.sv | 183 ++++++++++++++++++
 tb/tb_z80_io_cycle_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_cycle_gen.sv
// Z80 I/O bus-cycle master for the MSX cartridge slot: T1, T2, TW..., T3, gap sequencing
// with programmable T-state length, strobe edges, wait extension and timeout abort.
module z80_io_cycle_gen #(
  parameter int ADDR_W      = 16,
  parameter int T_CLKS      = 24,
  parameter int STROBE_DLY  = 12,
  parameter int RELEASE_DLY = 12,
  parameter int GAP_TSTATES = 2,
  parameter int TIMEOUT_TW  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              slot_clk,
  output logic [ADDR_W-1:0] slot_a,
  output logic [7:0]        slot_d_out,
  output logic              slot_d_oe,
  input  logic [7:0]        slot_d_in,
  output logic              slot_iorq_n,
  output logic              slot_rd_n,
  output logic              slot_wr_n,
  input  logic              slot_wait
);

  localparam int CNT_W = $clog2(T_CLKS);
  localparam int TW_W  = $clog2(TIMEOUT_TW + 1);
  localparam int GAP_W = (GAP_TSTATES > 1) ? $clog2(GAP_TSTATES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(T_CLKS / 2);
  localparam logic [CNT_W-1:0] STB_AT   = CNT_W'((STROBE_DLY > 0) ? STROBE_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] REL_AT   = CNT_W'((RELEASE_DLY > 0) ? RELEASE_DLY - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TSTATES - 1);
  localparam logic [TW_W-1:0]  TW_MAX   = TW_W'(TIMEOUT_TW);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [TW_W-1:0]  tw_cnt;
  logic [GAP_W-1:0] gap_t;
  logic             is_write;
  logic             aborted;
  logic             t_last;
  logic             gap_end;
  logic             start;
  logic             strobe_on;
  logic             strobe_off;

  // Edge decoding: every transition happens on the edge that ends the current clk slot
  always_comb begin
    t_last    = (cnt == CNT_LAST);
    cnt_nxt   = t_last ? '0 : cnt + CNT_W'(1);
    gap_end   = (state == S_GAP) && t_last && (gap_t == GAP_LAST);
    // A request waiting through the gap is taken on the edge the gap closes
    start     = req_valid && (req_ready || gap_end);
    strobe_on = (STROBE_DLY == 0) ? ((state == S_T1) && t_last)
                                  : ((state == S_T2) && (cnt == STB_AT));
    if (RELEASE_DLY == 0)
      strobe_off = ((state == S_T3) && t_last) || ((state == S_GAP) && aborted);
    else
      strobe_off = (state == S_GAP) && (aborted || ((gap_t == '0) && (cnt == REL_AT)));
    strobe_off = strobe_off && !start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tw_cnt      <= '0;
      gap_t       <= '0;
      is_write    <= 1'b0;
      aborted     <= 1'b0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      slot_clk    <= 1'b0;
      slot_a      <= '0;
      slot_d_out  <= 8'h00;
      slot_d_oe   <= 1'b0;
      slot_iorq_n <= 1'b1;
      slot_rd_n   <= 1'b1;
      slot_wr_n   <= 1'b1;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      if (start) begin
        state     <= S_T1;
        cnt       <= '0;
        slot_clk  <= 1'b1;
        busy      <= 1'b1;
        req_ready <= 1'b0;
        aborted   <= 1'b0;
        is_write  <= req_write;
        slot_a    <= req_address;
        if (req_write) begin
          slot_d_out <= req_wdata;
          slot_d_oe  <= 1'b1;
        end
      end else begin
        if (state != S_IDLE) begin
          cnt      <= cnt_nxt;
          slot_clk <= (cnt_nxt < CNT_HALF);
        end
        case (state)
          S_IDLE: begin
          end
          S_T1: if (t_last) state <= S_T2;
          S_T2: begin
            if (t_last) begin
              state  <= S_TW;
              tw_cnt <= TW_W'(1);
            end
          end
          S_TW: begin
            if (t_last) begin
              if (!slot_wait) begin
                state <= S_T3;
              end else if (tw_cnt == TW_MAX) begin
                // Target never released /WAIT: abandon the cycle without a T3
                state       <= S_GAP;
                gap_t       <= '0;
                aborted     <= 1'b1;
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b1;
              end else begin
                tw_cnt <= tw_cnt + TW_W'(1);
              end
            end
          end
          S_T3: begin
            if (t_last) begin
              state     <= S_GAP;
              gap_t     <= '0;
              rsp_valid <= 1'b1;
              if (!is_write) rsp_rdata <= slot_d_in;
            end
          end
          S_GAP: begin
            if (gap_end) begin
              state     <= S_IDLE;
              cnt       <= '0;
              slot_clk  <= 1'b0;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else if (t_last) begin
              gap_t <= gap_t + GAP_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (strobe_on) begin
        slot_iorq_n <= 1'b0;
        if (is_write) slot_wr_n <= 1'b0;
        else          slot_rd_n <= 1'b0;
      end
      if (strobe_off) begin
        slot_iorq_n <= 1'b1;
        slot_rd_n   <= 1'b1;
        slot_wr_n   <= 1'b1;
        slot_d_oe   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_z80_io_cycle_gen.sv
// Bench for z80_io_cycle_gen: timeline model (offsets from each accept edge) checked every
// cycle, plus literal spot checks at the edges that define the Z80 I/O cycle.
module tb_z80_io_cycle_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_address;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_timeout, busy, slot_clk;
  logic [7:0]  rsp_rdata;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_out, slot_d_in;
  logic        slot_d_oe, slot_iorq_n, slot_rd_n, slot_wr_n, slot_wait;

  always #5 clk = ~clk;

  z80_io_cycle_gen dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .busy(busy), .slot_clk(slot_clk), .slot_a(slot_a),
    .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe), .slot_d_in(slot_d_in),
    .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
    .slot_wait(slot_wait)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Transaction list: accept edge, direction, data, number of wait samples (-1 = never releases)
  int          t_e0  [16];
  logic        t_wr  [16];
  logic [15:0] t_a   [16];
  logic [7:0]  t_wd  [16];
  logic [7:0]  t_din [16];
  int          t_nw  [16];
  int          ntx     = 0;
  int          mbase   = 0;
  int          free_at = 0;

  function automatic int rsp_off(input int nw);
    return (nw < 0) ? (48 + 24 * 256) : (96 + 24 * nw);
  endfunction
  function automatic int rel_off(input int nw);
    return (nw < 0) ? rsp_off(nw) + 1 : rsp_off(nw) + 12;
  endfunction
  function automatic int done_off(input int nw);
    return rsp_off(nw) + 48;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                       input int nw, input logic [7:0] din, output int e0);
    int e;
    e = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    t_e0[ntx] = e; t_wr[ntx] = wr; t_a[ntx] = a; t_wd[ntx] = wd;
    t_nw[ntx] = nw; t_din[ntx] = din;
    ntx++;
    req_valid = 1'b1; req_write = wr; req_address = a; req_wdata = wd;
    wait_to(e);
    req_valid = 1'b0;
    free_at = e + done_off(nw);
    e0 = e;
  endtask

  // Target model: hold /WAIT for the requested number of TW samples, present read data
  initial begin
    int a, j;
    slot_wait = 1'b0;
    slot_d_in = 8'h00;
    forever begin
      @(negedge clk);
      a = -1;
      for (int i = mbase; i < ntx; i++) if (t_e0[i] <= cyc + 1) a = i;
      if (a < 0) begin
        slot_wait = 1'b0;
      end else begin
        j = cyc + 1 - t_e0[a];
        slot_d_in = t_din[a];
        if (j >= done_off(t_nw[a])) slot_wait = 1'b0;
        else if (t_nw[a] < 0)       slot_wait = 1'b1;
        else                        slot_wait = (j <= 48 + 24 * t_nw[a]);
      end
    end
  end

  // Per-cycle compare against the timeline model
  initial begin
    logic [15:0] ea;
    logic [7:0]  ed, er;
    logic        e_busy, e_clk, e_iorq, e_rd, e_wr, e_oe, e_rv, e_to;
    int          cur, k, ro;
    ea = '0; ed = '0; er = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      e_busy = 1'b0; e_clk = 1'b0; e_iorq = 1'b1; e_rd = 1'b1; e_wr = 1'b1;
      e_oe = 1'b0; e_rv = 1'b0; e_to = 1'b0;
      if (reset) begin
        mbase = ntx;
        ea = '0; ed = '0; er = '0;
      end else begin
        cur = -1;
        for (int i = mbase; i < ntx; i++) if (t_e0[i] <= cyc) cur = i;
        if (cur >= 0) begin
          k  = cyc - t_e0[cur];
          ro = rsp_off(t_nw[cur]);
          if (k == 0) begin
            ea = t_a[cur];
            if (t_wr[cur]) ed = t_wd[cur];
          end
          if (k == ro && !t_wr[cur] && t_nw[cur] >= 0) er = t_din[cur];
          if (k < done_off(t_nw[cur])) begin
            e_busy = 1'b1;
            e_clk  = ((k % 24) < 12);
            e_iorq = !(k >= 36 && k < rel_off(t_nw[cur]));
            e_wr   = t_wr[cur] ? e_iorq : 1'b1;
            e_rd   = t_wr[cur] ? 1'b1 : e_iorq;
            e_oe   = t_wr[cur] && (k < rel_off(t_nw[cur]));
            e_rv   = (k == ro);
            e_to   = (k == ro) && (t_nw[cur] < 0);
          end
        end
      end
      chk("busy",        busy,        e_busy);
      chk("req_ready",   req_ready,   !e_busy);
      chk("slot_clk",    slot_clk,    e_clk);
      chk("slot_iorq_n", slot_iorq_n, e_iorq);
      chk("slot_rd_n",   slot_rd_n,   e_rd);
      chk("slot_wr_n",   slot_wr_n,   e_wr);
      chk("slot_d_oe",   slot_d_oe,   e_oe);
      chk("rsp_valid",   rsp_valid,   e_rv);
      chk("rsp_timeout", rsp_timeout, e_to);
      chk("slot_a",      slot_a,      ea);
      chk("slot_d_out",  slot_d_out,  ed);
      chk("rsp_rdata",   rsp_rdata,   er);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e0b;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_iorq",  slot_iorq_n, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x89 <- 0x06, no wait
    issue(1'b1, 16'h0089, 8'h06, 0, 8'h00, e0);
    chk("w_addr", slot_a, 16'h0089);
    chk("w_oe",   slot_d_oe, 1'b1);
    wait_to(e0 + 35);  chk("w_iorq35", slot_iorq_n, 1'b1);
    wait_to(e0 + 36);  chk("w_iorq36", slot_iorq_n, 1'b0); chk("w_wr36", slot_wr_n, 1'b0);
    wait_to(e0 + 96);  chk("w_rsp96",  rsp_valid, 1'b1);
    wait_to(e0 + 107); chk("w_wr107",  slot_wr_n, 1'b0);
    wait_to(e0 + 108); chk("w_wr108",  slot_wr_n, 1'b1); chk("w_oe108", slot_d_oe, 1'b0);
    wait_to(e0 + 143); chk("w_rdy143", req_ready, 1'b0);
    wait_to(e0 + 144); chk("w_rdy144", req_ready, 1'b1);

    // Read 0x88 returning 0xA5, no wait
    issue(1'b0, 16'h0088, 8'h00, 0, 8'hA5, e0);
    wait_to(e0 + 36);  chk("r_rd36",   slot_rd_n, 1'b0); chk("r_oe36", slot_d_oe, 1'b0);
    wait_to(e0 + 96);  chk("r_data96", rsp_rdata, 8'hA5);
    wait_to(e0 + 107); chk("r_rd107",  slot_rd_n, 1'b0);
    wait_to(e0 + 108); chk("r_rd108",  slot_rd_n, 1'b1);
    wait_to(e0 + 150);

    // Read with three wait samples
    issue(1'b0, 16'h0098, 8'h00, 3, 8'h5A, e0);
    wait_to(e0 + 167); chk("wt_rsp167", rsp_valid, 1'b0);
    wait_to(e0 + 168); chk("wt_rsp168", rsp_valid, 1'b1); chk("wt_data", rsp_rdata, 8'h5A);
    wait_to(e0 + 220);

    // Wait never released: timeout after 256 TWs
    issue(1'b0, 16'h0099, 8'h00, -1, 8'h33, e0);
    wait_to(e0 + 6192);
    chk("to_rsp",  rsp_valid, 1'b1);
    chk("to_flag", rsp_timeout, 1'b1);
    chk("to_iorq_before", slot_iorq_n, 1'b0);
    wait_to(e0 + 6193);
    chk("to_iorq_after", slot_iorq_n, 1'b1);
    chk("to_data", rsp_rdata, 8'h5A);
    wait_to(e0 + 6250);

    // Back-to-back writes to the VDP control port: value then register select
    issue(1'b1, 16'h0099, 8'h24, 0, 8'h00, e0);
    fork
      issue(1'b1, 16'h0099, 8'h91, 0, 8'h00, e0b);
      begin
        wait_to(e0 + 96);  chk("bb_rsp1",    rsp_valid, 1'b1);
        wait_to(e0 + 97);  chk("bb_rsp1_end", rsp_valid, 1'b0);
        wait_to(e0 + 143); chk("bb_d143",    slot_d_out, 8'h24);
        wait_to(e0 + 144); chk("bb_d144",    slot_d_out, 8'h91); chk("bb_oe144", slot_d_oe, 1'b1);
        wait_to(e0 + 240); chk("bb_rsp2",    rsp_valid, 1'b1);
        wait_to(e0 + 241); chk("bb_rsp2_end", rsp_valid, 1'b0);
      end
    join
    wait_to(e0 + 300);

    // Reset landing mid-write
    issue(1'b1, 16'h0099, 8'h80, 0, 8'h00, e0);
    wait_to(e0 + 49);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_iorq", slot_iorq_n, 1'b1);
    chk("rs_wr",   slot_wr_n, 1'b1);
    chk("rs_oe",   slot_d_oe, 1'b0);
    chk("rs_rdy",  req_ready, 1'b1);
    reset = 1'b0;
    free_at = 0;
    repeat (120) @(negedge clk);

    // Recovery read after reset
    issue(1'b0, 16'h0088, 8'h00, 0, 8'h7E, e0);
    wait_to(e0 + 96);  chk("rec_data", rsp_rdata, 8'h7E);
    wait_to(e0 + 160);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
